// File: rtl/core_inst_seq_pkg.sv
// Instruction word field map shared by core and its sequencer, plus the
// sequencer state encoding.
package core_ctrl_pkg;

    localparam int INST_W     = 17;
    localparam int ADD_W      = 4;
    localparam int CNT_W      = 5;

    localparam int OFIFO_RD   = 16;
    localparam int QK_ADD_LSB = 12;
    localparam int P_ADD_LSB  = 8;
    localparam int EXEC       = 7;
    localparam int LOAD       = 6;
    localparam int QRD        = 5;
    localparam int QWR        = 4;
    localparam int KRD        = 3;
    localparam int KWR        = 2;
    localparam int PRD        = 1;
    localparam int PWR        = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_QWR,
        S_KWR,
        S_KLOAD,
        S_EXEC,
        S_DRAIN,
        S_XFER,
        S_PRD
    } seq_state_t;

endpackage

// File: rtl/core_inst_seq_if.sv
// Row input stream and instruction/data bus between the sequencer and core.
// master = sequencer side, slave = stream source / core side.
interface core_inst_seq_if #(
    parameter int pr = 8,
    parameter int bw = 8
);
    import core_ctrl_pkg::*;

    logic [pr*bw-1:0]  in_data;
    logic              in_valid;
    logic              in_ready;
    logic [INST_W-1:0] inst;
    logic [pr*bw-1:0]  mem_in;
    logic              out_valid;

    modport master (
        input  in_data, in_valid,
        output in_ready, inst, mem_in, out_valid
    );

    modport slave (
        output in_data, in_valid,
        input  in_ready, inst, mem_in, out_valid
    );

endinterface

// File: rtl/core_inst_seq_phase_counter.sv
// Shared phase counter: clear wins over enable; last flags cnt == terminal value.
module phase_counter
    import core_ctrl_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         en_i,
    input  logic [W-1:0] term_i,
    output logic [W-1:0] cnt_o,
    output logic         last_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == term_i);

endmodule

// File: rtl/core_inst_seq.sv
// Instruction sequencer for one attention-score run of core: Q/K row writes,
// K load, Q execute, drain, OFIFO->pmem transfer and pmem readback.
module core_inst_seq
    import core_ctrl_pkg::*;
#(
    parameter int bw    = 8,
    parameter int pr    = 8,
    parameter int col   = 8,
    parameter int rows  = 8,
    parameter int drain = 24
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            busy,
    output logic            done,
    core_inst_seq_if.master bus
);

    localparam int DW = pr * bw;

    localparam logic [CNT_W-1:0] ROWS_T  = CNT_W'(rows - 1);
    localparam logic [CNT_W-1:0] COL_T   = CNT_W'(col - 1);
    localparam logic [CNT_W-1:0] KLOAD_T = CNT_W'(col);
    localparam logic [CNT_W-1:0] EXEC_T  = CNT_W'(rows);
    localparam logic [CNT_W-1:0] DRAIN_T = CNT_W'((drain > 0) ? drain - 1 : 0);

    seq_state_t        state_q, state_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [DW-1:0]     mem_in_q, mem_in_d;
    logic              prd_last_q, prd_last_d;
    logic              out_valid_q, done_q;

    logic [CNT_W-1:0]  cnt, term;
    logic [ADD_W-1:0]  addr;
    logic              last, en, clear, in_ready, hs;

    assign in_ready = (state_q == S_QWR) || (state_q == S_KWR);
    assign hs       = bus.in_valid && in_ready;
    assign addr     = ADD_W'(cnt);
    assign clear    = (state_d != state_q);

    phase_counter #(.W(CNT_W)) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear_i(clear),
        .en_i   (en),
        .term_i (term),
        .cnt_o  (cnt),
        .last_o (last)
    );

    // Terminal count depends on state only, keeping last free of any comb loop.
    always_comb begin
        term = ROWS_T;
        en   = 1'b0;
        case (state_q)
            S_QWR:   begin term = ROWS_T;  en = hs;   end
            S_KWR:   begin term = COL_T;   en = hs;   end
            S_KLOAD: begin term = KLOAD_T; en = 1'b1; end
            S_EXEC:  begin term = EXEC_T;  en = 1'b1; end
            S_DRAIN: begin term = DRAIN_T; en = 1'b1; end
            S_XFER:  begin term = ROWS_T;  en = 1'b1; end
            S_PRD:   begin term = ROWS_T;  en = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        inst_d     = '0;
        mem_in_d   = mem_in_q;
        prd_last_d = 1'b0;
        case (state_q)
            S_IDLE: if (start) state_d = S_QWR;
            S_QWR, S_KWR: begin
                if (hs) begin
                    inst_d[(state_q == S_QWR) ? QWR : KWR] = 1'b1;
                    inst_d[QK_ADD_LSB +: ADD_W] = addr;
                    mem_in_d = bus.in_data;
                    if (last) state_d = (state_q == S_QWR) ? S_KWR : S_KLOAD;
                end
            end
            // Trailing word covers the one-cycle SRAM read latency.
            S_KLOAD: begin
                inst_d[LOAD] = 1'b1;
                if (last) begin
                    state_d = S_EXEC;
                end else begin
                    inst_d[KRD] = 1'b1;
                    inst_d[QK_ADD_LSB +: ADD_W] = addr;
                end
            end
            S_EXEC: begin
                inst_d[EXEC] = 1'b1;
                if (last) begin
                    state_d = (drain > 0) ? S_DRAIN : S_XFER;
                end else begin
                    inst_d[QRD] = 1'b1;
                    inst_d[QK_ADD_LSB +: ADD_W] = addr;
                end
            end
            S_DRAIN: if (last) state_d = S_XFER;
            S_XFER: begin
                inst_d[OFIFO_RD] = 1'b1;
                inst_d[PWR]      = 1'b1;
                inst_d[P_ADD_LSB +: ADD_W] = addr;
                if (last) state_d = S_PRD;
            end
            S_PRD: begin
                inst_d[PRD] = 1'b1;
                inst_d[P_ADD_LSB +: ADD_W] = addr;
                if (last) begin
                    state_d    = S_IDLE;
                    prd_last_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // done and out_valid trail the emitted word by one cycle to align with core.out.
    always_ff @(posedge clk) begin
        if (reset) begin
            inst_q      <= '0;
            mem_in_q    <= '0;
            prd_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            inst_q      <= inst_d;
            mem_in_q    <= mem_in_d;
            prd_last_q  <= prd_last_d;
            out_valid_q <= inst_q[PRD];
            done_q      <= prd_last_q;
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
    assign bus.in_ready  = in_ready;
    assign bus.inst      = inst_q;
    assign bus.mem_in    = mem_in_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_core_inst_seq.sv
// Bench for core_inst_seq: a word-list model of a full run is built from the
// field rules and compared cycle by cycle against the DUT outputs.
module tb_core_inst_seq;
    import core_ctrl_pkg::*;

    localparam int BW = 8, PR = 8, COL = 8, ROWS = 8, DRAIN = 24;
    localparam int DW = PR * BW;

    logic clk = 1'b0;
    logic reset, start, busy, done;

    core_inst_seq_if #(.pr(PR), .bw(BW)) bus ();

    core_inst_seq #(.bw(BW), .pr(PR), .col(COL), .rows(ROWS), .drain(DRAIN)) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .busy (busy),
        .done (done),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int n_done, n_ov;
    logic [DW-1:0]     exp_mem = '0;
    logic [INST_W-1:0] cap [0:511];
    logic [INST_W-1:0] mw [$];
    logic [DW-1:0]     md [$];
    bit                mwr [$];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [INST_W-1:0] w, input logic [DW-1:0] d, input bit wr);
        mw.push_back(w);
        md.push_back(d);
        mwr.push_back(wr);
    endtask

    task automatic drive_idle();
        bus.in_valid = 1'($urandom);
        bus.in_data  = {$urandom, $urandom};
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_inst"},  bus.inst, '0);
        chk({tag, "_mem"},   bus.mem_in, '0);
        chk({tag, "_busy"},  busy, 1'b0);
        chk({tag, "_rdy"},   bus.in_ready, 1'b0);
        chk({tag, "_done"},  done, 1'b0);
        chk({tag, "_ov"},    bus.out_valid, 1'b0);
    endtask

    // Called at a negedge; leaves the bench at a negedge.
    task automatic run(input int stall_max, input bit toggle, input bit seq_data,
                       input bit mid_start, input bit mid_reset, input bit chain);
        logic [INST_W-1:0] w;
        logic [DW-1:0]     dv;
        int n, nwr, last, ns, exec_idx, drain_idx, start_at, reset_at;
        mw.delete(); md.delete(); mwr.delete();
        for (int b = 0; b < ROWS + COL; b++) begin
            ns = toggle ? ((b > 0 && b < ROWS) ? 1 : 0) : int'($urandom_range(stall_max, 0));
            repeat (ns) push('0, '0, 1'b0);
            dv = seq_data ? DW'(b + 1) : {$urandom, $urandom};
            w = '0;
            w[(b < ROWS) ? QWR : KWR] = 1'b1;
            w[QK_ADD_LSB +: 4] = 4'((b < ROWS) ? b : b - ROWS);
            push(w, dv, 1'b1);
        end
        nwr = mw.size();
        for (int k = 0; k <= COL; k++) begin
            w = '0; w[LOAD] = 1'b1;
            if (k < COL) begin w[KRD] = 1'b1; w[QK_ADD_LSB +: 4] = 4'(k); end
            push(w, '0, 1'b0);
        end
        exec_idx = mw.size();
        for (int r = 0; r <= ROWS; r++) begin
            w = '0; w[EXEC] = 1'b1;
            if (r < ROWS) begin w[QRD] = 1'b1; w[QK_ADD_LSB +: 4] = 4'(r); end
            push(w, '0, 1'b0);
        end
        drain_idx = mw.size();
        repeat (DRAIN) push('0, '0, 1'b0);
        for (int r = 0; r < ROWS; r++) begin
            w = '0; w[OFIFO_RD] = 1'b1; w[PWR] = 1'b1; w[P_ADD_LSB +: 4] = 4'(r);
            push(w, '0, 1'b0);
        end
        for (int r = 0; r < ROWS; r++) begin
            w = '0; w[PRD] = 1'b1; w[P_ADD_LSB +: 4] = 4'(r);
            push(w, '0, 1'b0);
        end
        n        = mw.size();
        start_at = mid_start ? exec_idx + 3 : -1;
        reset_at = mid_reset ? drain_idx + 6 : -1;
        last     = chain ? n + 2 : n + 3;
        n_done = 0; n_ov = 0;

        start = 1'b1;
        drive_idle();
        for (int c = 1; c <= last; c++) begin
            @(posedge clk); @(negedge clk);
            w = (c >= 2 && c - 2 < n) ? mw[c-2] : '0;
            if (c >= 2 && c - 2 < n && mwr[c-2]) exp_mem = md[c-2];
            cap[c] = bus.inst;
            chk($sformatf("inst@%0d", c), bus.inst, w);
            chk($sformatf("mem_in@%0d", c), bus.mem_in, exp_mem);
            chk($sformatf("busy@%0d", c), busy, c <= n);
            chk($sformatf("in_ready@%0d", c), bus.in_ready, c <= nwr);
            chk($sformatf("done@%0d", c), done, c == n + 2);
            chk($sformatf("out_valid@%0d", c), bus.out_valid, c >= n - ROWS + 3 && c <= n + 2);
            if (done) n_done++;
            if (bus.out_valid) n_ov++;
            if (chain && c == last) break;
            start = (c == start_at);
            reset = (c == reset_at);
            if (c <= nwr) begin
                bus.in_valid = mwr[c-1];
                bus.in_data  = mwr[c-1] ? md[c-1] : {$urandom, $urandom};
            end else begin
                drive_idle();
            end
            if (reset) begin
                @(posedge clk); @(negedge clk);
                chk_reset_vals("mid_rst");
                exp_mem = '0;
                reset = 1'b0;
                start = 1'b0;
                repeat (10) begin
                    @(posedge clk); @(negedge clk);
                    chk("post_rst_done", done, 1'b0);
                    chk("post_rst_busy", busy, 1'b0);
                    if (done) n_done++;
                end
                break;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0;
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            chk_reset_vals("rst");
        end
        reset = 1'b0; start = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("idle_busy", busy, 1'b0);
        chk("idle_inst", bus.inst, '0);

        // Full run, no stalls, rows 0x01..0x10.
        run(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("full_done_cnt", n_done, 1);
        chk("full_ov_cnt", n_ov, ROWS);
        chk("enc_qwr0",   cap[2],  17'h00010);
        chk("enc_kwr0",   cap[10], 17'h00004);
        chk("enc_kload0", cap[18], 17'h00048);
        chk("enc_kload1", cap[19], 17'h01048);
        chk("enc_kload7", cap[25], 17'h07048);
        chk("enc_kload_t", cap[26], 17'h00040);
        chk("enc_exec0",  cap[27], 17'h000A0);
        chk("enc_xfer3",  cap[63], 17'h10301);
        chk("enc_prd3",   cap[71], 17'h00302);

        // Toggling in_valid during QWR.
        run(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("stall_done_cnt", n_done, 1);
        chk("stall_ov_cnt", n_ov, ROWS);

        // start pulsed mid-EXEC; next run starts on the done cycle.
        run(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("midstart_done_cnt", n_done, 1);
        run(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("b2b_done_cnt", n_done, 1);
        chk("b2b_ov_cnt", n_ov, ROWS);

        // Reset in DRAIN, then a fresh run.
        run(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rst_run_done_cnt", n_done, 0);
        run(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("after_rst_done_cnt", n_done, 1);
        chk("after_rst_ov_cnt", n_ov, ROWS);
        run(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rand_done_cnt", n_done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
